dfe_stage_scheduler: RTL and testbench
======================================

Name: dfe_stage_scheduler

Overview:
Sequencing and configuration controller for the DFE post-decimation IIR chain, i.e. the cascaded notch stages after the fractional decimator.
- Replaces free-running divided clocks with single-cycle stage enables derived from the decimator `valid`, so all stages run on CLK.
- Holds a shadow/active coefficient bank per stage (b0, b1, b2, a1, a2).
- Commits new coefficients atomically, only between samples, so no sample is filtered with mixed coefficient sets.

Parameters:
- NUM_STAGES, 2: number of cascaded biquad/notch stages sequenced.
- COEF_W, 16: coefficient width (signed, s16.14).
- ADDR_W, 4: config address width; must satisfy 2^ADDR_W >= 5*NUM_STAGES.
- B0_RST, 16'h4000: reset value of b0 and b2 in shadow and active banks. All other coefficients reset to 0.

Ports:
- CLK, input, 1: system clock, rising edge.
- RST, input, 1: asynchronous reset, active-high.
- fd_valid, input, 1: decimator output-sample strobe.
- cfg_wr, input, 1: shadow register write strobe.
- cfg_addr, input, ADDR_W: write address = stage*5 + idx, with idx 0..4 = b0, b1, b2, a1, a2.
- cfg_data, input, COEF_W: write data.
- cfg_commit, input, 1: request copy of shadow bank to active bank.
- stage_en, output, NUM_STAGES: one-hot, single-cycle enable per stage.
- out_valid, output, 1: final stage output valid pulse.
- busy, output, 1: a sample sequence is in flight.
- commit_pending, output, 1: a commit is requested but not yet applied.
- commit_done, output, 1: one-cycle pulse after the active bank is updated.
- overrun, output, 1: one-cycle pulse when fd_valid is dropped.
- coef_active, output, NUM_STAGES*5*COEF_W: flattened active bank. Stage s, idx i occupies bits [(s*5+i)*COEF_W +: COEF_W].

Behaviour:
- Reset (async, RST=1):
  - FSM = IDLE.
  - stage_en, out_valid, busy, commit_pending, commit_done, overrun = 0.
  - Shadow and active banks: b0 and b2 = B0_RST, others = 0.
  - An in-flight sequence is abandoned and no further enables are issued.
- FSM states: IDLE, RUN, COMMIT.
- Stage sequencing:
  - fd_valid sampled high in IDLE or COMMIT at edge t → stage_en[0]=1 in cycle t+1; stage_en[k]=1 in cycle t+1+k.
  - out_valid=1 in cycle t+1+NUM_STAGES.
  - busy=1 in cycles t+1 .. t+NUM_STAGES.
  - Sequence timing is driven by a stage counter (0..NUM_STAGES-1). RUN → IDLE after the last stage_en.
- Overrun: fd_valid=1 while in RUN → the sample is ignored, overrun pulses in the next cycle, and the current sequence continues unchanged.
- Writes:
  - cfg_wr writes the shadow register at cfg_addr in any state, including RUN and COMMIT.
  - Addresses >= 5*NUM_STAGES are ignored.
  - The active bank never changes on a write.
- Commit request:
  - cfg_commit sets commit_pending on the next edge.
  - Repeated requests while pending merge into one.
- Commit application:
  - IDLE with commit_pending=1 and fd_valid=0 → COMMIT.
  - On the edge leaving COMMIT: active ← shadow, commit_pending cleared, commit_done=1 for the following cycle.
- Priority:
  - In IDLE, fd_valid beats a pending commit; the commit follows after the sequence ends.
  - fd_valid during COMMIT → COMMIT → RUN, and stage_en[0] uses the new coefficients.
- Same-cycle corner cases in the COMMIT cycle:
  - A cfg_wr lands in shadow but is not part of this commit.
  - A cfg_commit re-arms commit_pending after the clear.
- Stable bank: coef_active is constant whenever busy=1 or any stage_en is high.

Optional Feature:
- Macro: DFE_SCHED_STATS_EN.
- When defined, two extra outputs are added:
  - sample_cnt [31:0]: counts accepted fd_valid samples.
  - overrun_cnt [15:0]: counts dropped samples; saturates at 16'hFFFF.
  - Both reset to 0 on RST.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then idle: after RST release, coef_active stage0 = {b0=4000, b1=0, b2=4000, a1=0, a2=0}; all outputs 0; no stage_en without fd_valid.
- Single sample, NUM_STAGES=2: fd_valid pulse at edge 10 → stage_en=01 in cycle 11, 10 in cycle 12, out_valid in cycle 13; busy high in cycles 11–12.
- Overrun: fd_valid at edges 10 and 11 → one sequence only; overrun pulse in cycle 12; stage_en pattern unchanged.
- Atomic commit:
  - Setup: write addr 1 = 16'h678E and addr 6 = 16'hC000; assert cfg_commit during RUN.
  - Required: active bank unchanged until the sequence ends.
  - Required: COMMIT state follows, then commit_done pulses and the new values appear.
- Collision: cfg_commit pending and fd_valid both high in IDLE → sequence runs first with old coefficients, then commit. A separate fd_valid arriving during COMMIT → its stage_en[0] sees the new coefficients.
- Mid-sequence reset: assert RST in cycle 12 of a sequence → stage_en and out_valid are 0 immediately; banks return to reset values.

Source files
------------

// File: rtl/dfe_stage_scheduler_if.sv
// Sample-sequencing and coefficient-configuration bus for dfe_stage_scheduler.
// Optional statistics outputs exist only when DFE_SCHED_STATS_EN is defined.
interface dfe_stage_scheduler_if #(
    parameter int NUM_STAGES = 2,
    parameter int COEF_W     = 16,
    parameter int ADDR_W     = 4
);
    logic                             fd_valid;
    logic                             cfg_wr;
    logic [ADDR_W-1:0]                cfg_addr;
    logic [COEF_W-1:0]                cfg_data;
    logic                             cfg_commit;
    logic [NUM_STAGES-1:0]            stage_en;
    logic                             out_valid;
    logic                             busy;
    logic                             commit_pending;
    logic                             commit_done;
    logic                             overrun;
    logic [NUM_STAGES*5*COEF_W-1:0]   coef_active;
`ifdef DFE_SCHED_STATS_EN
    logic [31:0]                      sample_cnt;
    logic [15:0]                      overrun_cnt;

    modport master (
        output fd_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        input  stage_en, out_valid, busy, commit_pending, commit_done, overrun, coef_active,
        input  sample_cnt, overrun_cnt
    );
    modport slave (
        input  fd_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        output stage_en, out_valid, busy, commit_pending, commit_done, overrun, coef_active,
        output sample_cnt, overrun_cnt
    );
`else
    modport master (
        output fd_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        input  stage_en, out_valid, busy, commit_pending, commit_done, overrun, coef_active
    );
    modport slave (
        input  fd_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        output stage_en, out_valid, busy, commit_pending, commit_done, overrun, coef_active
    );
`endif
endinterface

// File: rtl/dfe_stage_scheduler.sv
// Stage-enable sequencer and shadow/active coefficient banks for the post-decimation IIR chain.
// Define DFE_SCHED_STATS_EN to add the accepted/dropped sample counters.
module dfe_stage_scheduler #(
    parameter int                NUM_STAGES = 2,
    parameter int                COEF_W     = 16,
    parameter int                ADDR_W     = 4,
    parameter logic [COEF_W-1:0] B0_RST     = 16'h4000
) (
    input  logic                  CLK,
    input  logic                  RST,
    dfe_stage_scheduler_if.slave  bus
);
    localparam int NUM_REGS = 5 * NUM_STAGES;
    localparam int CNT_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // b0 and b2 come up as unity gain, every other tap as zero
    function automatic logic [COEF_W-1:0] coef_rst(input int idx);
        if (((idx % 5) == 0) || ((idx % 5) == 2)) begin
            return B0_RST;
        end else begin
            return {COEF_W{1'b0}};
        end
    endfunction

    state_t                         r_state, w_state_nxt;
    logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
    logic [NUM_STAGES-1:0]          r_stage_en, w_stage_en_nxt;
    logic                           r_out_valid, w_out_valid_nxt;
    logic                           r_busy, w_busy_nxt;
    logic                           r_overrun, w_overrun_nxt;
    logic                           r_pending, w_pending_nxt;
    logic                           r_done;
    logic                           w_apply, w_accept, w_wr_hit;
    logic [COEF_W-1:0]              r_shadow [NUM_REGS];
    logic [COEF_W-1:0]              r_active [NUM_REGS];
    logic [NUM_REGS*COEF_W-1:0]     w_coef_flat;

    assign w_wr_hit = bus.cfg_wr && (int'(bus.cfg_addr) < NUM_REGS);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a new sample always wins over a pending commit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.fd_valid) begin
                    w_state_nxt = S_RUN;
                end else if (r_pending) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_COMMIT: begin
                if (bus.fd_valid) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes and counter
    always_comb begin
        w_stage_en_nxt  = {NUM_STAGES{1'b0}};
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_apply         = 1'b0;
        w_accept        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.fd_valid;
            end
            S_RUN: begin
                w_overrun_nxt = bus.fd_valid;
                if (r_cnt == LAST_CNT) begin
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_stage_en_nxt = r_stage_en << 1;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                w_apply  = 1'b1;
                w_accept = bus.fd_valid;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
        if (w_accept) begin
            w_stage_en_nxt = NUM_STAGES'(1);
            w_busy_nxt     = 1'b1;
            w_cnt_nxt      = {CNT_W{1'b0}};
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
        // a request arriving in the COMMIT cycle re-arms after the clear
        if (bus.cfg_commit) begin
            w_pending_nxt = 1'b1;
        end else if (w_apply) begin
            w_pending_nxt = 1'b0;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Registered control outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_stage_en  <= {NUM_STAGES{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_stage_en  <= w_stage_en_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_overrun   <= w_overrun_nxt;
            r_pending   <= w_pending_nxt;
            r_done      <= w_apply;
        end
    end

    // Coefficient banks: active only loads from shadow on the edge leaving COMMIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= coef_rst(i);
                r_active[i] <= coef_rst(i);
            end
        end else begin
            if (w_apply) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_wr_hit) begin
                r_shadow[bus.cfg_addr] <= bus.cfg_data;
            end
        end
    end

    // Flatten active bank for the output bus
    always_comb begin
        w_coef_flat = {(NUM_REGS*COEF_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_coef_flat[i*COEF_W +: COEF_W] = r_active[i];
        end
    end

    assign bus.stage_en       = r_stage_en;
    assign bus.out_valid      = r_out_valid;
    assign bus.busy           = r_busy;
    assign bus.overrun        = r_overrun;
    assign bus.commit_pending = r_pending;
    assign bus.commit_done    = r_done;
    assign bus.coef_active    = w_coef_flat;

`ifdef DFE_SCHED_STATS_EN
    logic [31:0] r_sample_cnt;
    logic [15:0] r_overrun_cnt;

    // Accepted and dropped sample counters; dropped count saturates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sample_cnt  <= 32'd0;
            r_overrun_cnt <= 16'd0;
        end else begin
            if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
            if (w_overrun_nxt && (r_overrun_cnt != 16'hFFFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 16'd1;
            end
        end
    end

    assign bus.sample_cnt  = r_sample_cnt;
    assign bus.overrun_cnt = r_overrun_cnt;
`endif
endmodule

// File: tb/tb_dfe_stage_scheduler.sv
// Directed bench for dfe_stage_scheduler: per-cycle expected strobes are queued
// when stimulus is driven and popped as each DUT cycle is observed.
module tb_dfe_stage_scheduler;
    localparam int N    = 2;
    localparam int W    = 16;
    localparam int AW   = 4;
    localparam int NREG = N * 5;
    localparam int TOT  = NREG * W;

    typedef struct packed {
        logic [N-1:0] en;
        logic         ov;
        logic         busy;
        logic         ovr;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dfe_stage_scheduler_if #(.NUM_STAGES(N), .COEF_W(W), .ADDR_W(AW)) sif ();

    dfe_stage_scheduler #(
        .NUM_STAGES(N), .COEF_W(W), .ADDR_W(AW), .B0_RST(16'h4000)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (sif.slave)
    );

    exp_t           exp_q[$];
    logic [TOT-1:0] exp_shadow, exp_active, rst_bank;
    logic [5*W-1:0] stage0_rst;
    int             n_cmp  = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ensure(input int k);
        while (exp_q.size() <= k) exp_q.push_back('0);
    endtask

    // expected sequence for a sample accepted at the coming edge
    task automatic push_seq();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            ensure(k);
            e = exp_q[k];
            e.en   = e.en | (N'(1) << k);
            e.busy = 1'b1;
            exp_q[k] = e;
        end
        ensure(N);
        e = exp_q[N];
        e.ov = 1'b1;
        exp_q[N] = e;
    endtask

    task automatic mark_ovr(input int k);
        exp_t e;
        ensure(k);
        e = exp_q[k];
        e.ovr = 1'b1;
        exp_q[k] = e;
    endtask

    task automatic mark_done(input int k);
        exp_t e;
        ensure(k);
        e = exp_q[k];
        e.done = 1'b1;
        exp_q[k] = e;
    endtask

    // one clock edge, then compare every output against the front of the queue
    task automatic cycle();
        logic [TOT-1:0] snap;
        exp_t           e;
        snap = exp_shadow;
        @(posedge clk);
        #1;
        if (sif.cfg_wr && (int'(sif.cfg_addr) < NREG)) exp_shadow[int'(sif.cfg_addr)*W +: W] = sif.cfg_data;
        sif.fd_valid   = 1'b0;
        sif.cfg_wr     = 1'b0;
        sif.cfg_commit = 1'b0;
        @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        if (e.done) exp_active = snap;
        chk("stage_en", 256'(sif.stage_en), 256'(e.en));
        chk("out_valid", 256'(sif.out_valid), 256'(e.ov));
        chk("busy", 256'(sif.busy), 256'(e.busy));
        chk("overrun", 256'(sif.overrun), 256'(e.ovr));
        chk("commit_done", 256'(sif.commit_done), 256'(e.done));
        chk("coef_active", 256'(sif.coef_active), 256'(exp_active));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        sif.cfg_wr   = 1'b1;
        sif.cfg_addr = a;
        sif.cfg_data = d;
        cycle();
    endtask

    initial begin
        rst            = 1'b1;
        sif.fd_valid   = 1'b0;
        sif.cfg_wr     = 1'b0;
        sif.cfg_addr   = '0;
        sif.cfg_data   = '0;
        sif.cfg_commit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rst_bank[i*W +: W] = (((i % 5) == 0) || ((i % 5) == 2)) ? 16'h4000 : 16'h0000;
        end
        stage0_rst = {16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h4000};
        exp_shadow = rst_bank;
        exp_active = rst_bank;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stage_en", 256'(sif.stage_en), 256'(0));
        chk("rst_out_valid", 256'(sif.out_valid), 256'(0));
        chk("rst_busy", 256'(sif.busy), 256'(0));
        chk("rst_pending", 256'(sif.commit_pending), 256'(0));
        chk("rst_done", 256'(sif.commit_done), 256'(0));
        chk("rst_overrun", 256'(sif.overrun), 256'(0));
        rst = 1'b0;
        chk("rst_stage0_coef", 256'(sif.coef_active[5*W-1:0]), 256'(stage0_rst));
        repeat (3) cycle();

        // single sample
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        repeat (N + 2) cycle();

        // overrun on the second strobe, then a back-to-back accept in the out_valid cycle
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        sif.fd_valid = 1'b1;
        mark_ovr(0);
        cycle();
        cycle();
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        repeat (N + 2) cycle();

        // atomic commit requested during RUN
        wr(4'd1, 16'h678E);
        wr(4'd6, 16'hC000);
        wr(4'd12, 16'hDEAD);
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        sif.cfg_commit = 1'b1;
        mark_done(3);
        cycle();
        chk("pending_run", 256'(sif.commit_pending), 256'(1));
        cycle();
        chk("pending_ovalid", 256'(sif.commit_pending), 256'(1));
        cycle();
        chk("pending_commit", 256'(sif.commit_pending), 256'(1));
        cycle();
        chk("pending_cleared", 256'(sif.commit_pending), 256'(0));
        chk("commit_b1_s0", 256'(sif.coef_active[1*W +: W]), 256'(16'h678E));
        chk("commit_b1_s1", 256'(sif.coef_active[6*W +: W]), 256'(16'hC000));
        repeat (2) cycle();

        // collision: pending commit and fd_valid together in IDLE
        sif.cfg_wr     = 1'b1;
        sif.cfg_addr   = 4'd0;
        sif.cfg_data   = 16'h1234;
        sif.cfg_commit = 1'b1;
        cycle();
        chk("pending_idle", 256'(sif.commit_pending), 256'(1));
        sif.fd_valid = 1'b1;
        push_seq();
        mark_done(4);
        cycle();
        chk("old_coef_in_run", 256'(sif.coef_active[0 +: W]), 256'(16'h4000));
        repeat (3) cycle();
        // now in COMMIT: new sample, late write and re-arm all land here
        sif.fd_valid   = 1'b1;
        sif.cfg_wr     = 1'b1;
        sif.cfg_addr   = 4'd2;
        sif.cfg_data   = 16'h7777;
        sif.cfg_commit = 1'b1;
        push_seq();
        mark_done(4);
        cycle();
        chk("new_coef_at_en0", 256'(sif.coef_active[0 +: W]), 256'(16'h1234));
        chk("late_wr_excluded", 256'(sif.coef_active[2*W +: W]), 256'(16'h4000));
        chk("pending_rearmed", 256'(sif.commit_pending), 256'(1));
        repeat (4) cycle();
        chk("late_wr_committed", 256'(sif.coef_active[2*W +: W]), 256'(16'h7777));
        repeat (2) cycle();

        // reset in the second cycle of a sequence
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("midrst_stage_en", 256'(sif.stage_en), 256'(0));
        chk("midrst_out_valid", 256'(sif.out_valid), 256'(0));
        chk("midrst_busy", 256'(sif.busy), 256'(0));
        chk("midrst_coef", 256'(sif.coef_active), 256'(rst_bank));
        exp_q.delete();
        exp_shadow = rst_bank;
        exp_active = rst_bank;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        // committing right after reset proves the shadow bank was reset too
        sif.cfg_commit = 1'b1;
        mark_done(2);
        cycle();
        repeat (3) cycle();
        sif.fd_valid = 1'b1;
        push_seq();
        cycle();
        repeat (N + 2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
